timer_ctrl: RTL and testbench

//  Run-control sequencer for the prescaled timer datapath: owns the prescaler

---
 rtl/timer_ctrl.sv | 147 ++++++++++++++
 tb/tb_timer_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: run-control sequencer for the prescaled timer.
// Owns the prescaler counter, main counter, mode FSM, PWM/compare output
// and the tick/overflow/match strobes. Config is latched into shadow
// registers on start and at every period wrap so that a live change never
// corrupts the period in progress.
module timer_ctrl #(
   parameter int TIMER_BITS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  stop,
   input  logic                  clear,
   input  logic                  one_shot,
   input  logic [TIMER_BITS-1:0] prescaler,
   input  logic [TIMER_BITS-1:0] period,
   input  logic [TIMER_BITS-1:0] compare,
   output logic [TIMER_BITS-1:0] cnt,
   output logic                  tick,
   output logic                  ovf,
   output logic                  cmp_match,
   output logic                  pwm,
   output logic                  busy,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10,
      S_DONE   = 2'b11
   } state_t;

   state_t                state_q, state_d;
   logic [TIMER_BITS-1:0] pre_q, pre_d;
   logic [TIMER_BITS-1:0] cnt_q, cnt_d;
   logic [TIMER_BITS-1:0] pres_s_q, pres_s_d;
   logic [TIMER_BITS-1:0] per_s_q, per_s_d;
   logic [TIMER_BITS-1:0] cmp_s_q, cmp_s_d;
   logic                  os_s_q, os_s_d;
   logic                  tick_q, tick_d;
   logic                  ovf_q, ovf_d;
   logic                  match_q, match_d;
   logic                  pwm_q, pwm_d;
   logic                  busy_q, busy_d;

   // Registers: synchronous active-low reset clears control, counters and shadows.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         pre_q    <= '0;
         cnt_q    <= '0;
         pres_s_q <= '0;
         per_s_q  <= '0;
         cmp_s_q  <= '0;
         os_s_q   <= 1'b0;
         tick_q   <= 1'b0;
         ovf_q    <= 1'b0;
         match_q  <= 1'b0;
         pwm_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pre_q    <= pre_d;
         cnt_q    <= cnt_d;
         pres_s_q <= pres_s_d;
         per_s_q  <= per_s_d;
         cmp_s_q  <= cmp_s_d;
         os_s_q   <= os_s_d;
         tick_q   <= tick_d;
         ovf_q    <= ovf_d;
         match_q  <= match_d;
         pwm_q    <= pwm_d;
         busy_q   <= busy_d;
      end
   end

   // Next state: commands in priority stop > clear > start > pause, then counting.
   always_comb begin
      state_d  = state_q;
      pre_d    = pre_q;
      cnt_d    = cnt_q;
      pres_s_d = pres_s_q;
      per_s_d  = per_s_q;
      cmp_s_d  = cmp_s_q;
      os_s_d   = os_s_q;
      tick_d   = 1'b0;
      ovf_d    = 1'b0;
      match_d  = 1'b0;

      if (stop) begin
         state_d = S_IDLE;
         pre_d   = '0;
         cnt_d   = '0;
      end else if (clear) begin
         pre_d = '0;
         cnt_d = '0;
      end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
         pres_s_d = prescaler;
         per_s_d  = period;
         cmp_s_d  = compare;
         os_s_d   = one_shot;
         pre_d    = '0;
         cnt_d    = '0;
         state_d  = S_RUN;
      end else if (start && state_q == S_PAUSED) begin
         // Resume keeps pre_cnt so the partial prescale interval is honoured.
         state_d = S_RUN;
      end else if (pause && state_q == S_RUN) begin
         state_d = S_PAUSED;
      end else if (state_q == S_RUN) begin
         if (pre_q == pres_s_q) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (cnt_q == per_s_q) begin
               cnt_d    = '0;
               ovf_d    = 1'b1;
               pres_s_d = prescaler;
               per_s_d  = period;
               cmp_s_d  = compare;
               os_s_d   = one_shot;
               if (os_s_q) begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + TIMER_BITS'(1);
            end
            match_d = (cnt_d == cmp_s_d);
         end else begin
            pre_d = pre_q + TIMER_BITS'(1);
         end
      end

      busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
      pwm_d  = busy_d && (cnt_d < cmp_s_d);
   end

   assign cnt       = cnt_q;
   assign tick      = tick_q;
   assign ovf       = ovf_q;
   assign cmp_match = match_q;
   assign pwm       = pwm_q;
   assign busy      = busy_q;
   assign state     = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Testbench for timer_ctrl: directed scenarios followed by random commands,
// every cycle compared against a behavioural model of the timer.
module tb_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, pause, stop, clear, one_shot;
   logic [31:0] prescaler, period, compare;
   logic [31:0] cnt;
   logic        tick, ovf, cmp_match, pwm, busy;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   int ovf_seen = 0;
   int tick_seen = 0;

   // Model state: phase is 0 idle, 1 running, 2 paused, 3 done.
   int          m_phase;
   logic [31:0] m_pre, m_cnt, m_ps, m_pp, m_pc;
   logic        m_os, m_tick, m_ovf, m_match, m_pwm;

   timer_ctrl #(.TIMER_BITS(32)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
      .clear(clear), .one_shot(one_shot), .prescaler(prescaler),
      .period(period), .compare(compare), .cnt(cnt), .tick(tick),
      .ovf(ovf), .cmp_match(cmp_match), .pwm(pwm), .busy(busy),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void load_config();
      m_ps = prescaler;
      m_pp = period;
      m_pc = compare;
      m_os = one_shot;
   endfunction

   // Behavioural timer: one prescaled tick every m_ps+1 running cycles,
   // the counter walks 0..m_pp and wraps, reloading config at the wrap.
   task automatic model_edge();
      m_tick  = 1'b0;
      m_ovf   = 1'b0;
      m_match = 1'b0;
      if (!rst) begin
         m_phase = 0;
         m_pre = 0; m_cnt = 0; m_ps = 0; m_pp = 0; m_pc = 0; m_os = 1'b0;
      end else if (stop) begin
         m_phase = 0; m_pre = 0; m_cnt = 0;
      end else if (clear) begin
         m_pre = 0; m_cnt = 0;
      end else if (start && (m_phase == 0 || m_phase == 3)) begin
         load_config();
         m_pre = 0; m_cnt = 0; m_phase = 1;
      end else if (start && m_phase == 2) begin
         m_phase = 1;
      end else if (pause && m_phase == 1) begin
         m_phase = 2;
      end else if (m_phase == 1) begin
         if (m_pre < m_ps) begin
            m_pre = m_pre + 1;
         end else begin
            m_pre  = 0;
            m_tick = 1'b1;
            if (m_cnt < m_pp) begin
               m_cnt = m_cnt + 1;
            end else begin
               m_cnt = 0;
               m_ovf = 1'b1;
               if (m_os) m_phase = 3;
               load_config();
            end
            m_match = (m_cnt == m_pc);
         end
      end
      m_pwm = (m_phase == 1 || m_phase == 2) && (m_cnt < m_pc);
   endtask

   task automatic compare_all();
      check("cnt", cnt, m_cnt);
      check("tick", 32'(tick), 32'(m_tick));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("cmp_match", 32'(cmp_match), 32'(m_match));
      check("pwm", 32'(pwm), 32'(m_pwm));
      check("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      check("state", 32'(state), 32'(m_phase));
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         compare_all();
         if (ovf) ovf_seen++;
         if (tick) tick_seen++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1; cyc(1); stop = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; clear = 1'b0;
      one_shot = 1'b0; prescaler = 0; period = 0; compare = 0;

      // Reset state
      cyc(3);
      check("reset_state", 32'(state), 32'd0);
      check("reset_cnt", cnt, 32'd0);
      rst = 1'b1;
      cyc(2);

      // Periodic run, prescaler 3, period 4
      prescaler = 3; period = 4; compare = 2; one_shot = 1'b0;
      pulse_start();
      ovf_seen = 0; tick_seen = 0;
      cyc(40);
      check("t1_ovf_count", 32'(ovf_seen), 32'd2);
      check("t1_tick_count", 32'(tick_seen), 32'd10);
      do_stop();

      // One-shot, prescaler 0, period 2
      prescaler = 0; period = 2; one_shot = 1'b1;
      pulse_start();
      cyc(3);
      check("t2_ovf", 32'(ovf), 32'd1);
      check("t2_state_done", 32'(state), 32'd3);
      check("t2_busy", 32'(busy), 32'd0);
      cyc(4);
      do_stop();

      // PWM with compare 2, then 0, then 7
      prescaler = 0; period = 4; compare = 2; one_shot = 1'b0;
      pulse_start();
      cyc(12);
      compare = 0;
      cyc(12);
      compare = 7;
      cyc(12);
      check("t3_pwm_high", 32'(pwm), 32'd1);
      do_stop();

      // Pause at cnt 2 then resume
      prescaler = 3; period = 4; compare = 3;
      pulse_start();
      for (int k = 0; k < 50 && cnt != 2; k++) cyc(1);
      check("t4_reach_cnt2", cnt, 32'd2);
      pause = 1'b1; cyc(1); pause = 1'b0;
      tick_seen = 0;
      cyc(10);
      check("t4_frozen_cnt", cnt, 32'd2);
      check("t4_no_tick", 32'(tick_seen), 32'd0);
      pulse_start();
      cyc(12);

      // Live period change 4 -> 9 while running
      period = 9;
      cyc(60);
      do_stop();

      // Clear on a tick edge
      prescaler = 0; period = 9;
      pulse_start();
      cyc(3);
      clear = 1'b1; cyc(1); clear = 1'b0;
      check("t5_clear_cnt", cnt, 32'd0);
      check("t5_clear_tick", 32'(tick), 32'd0);
      cyc(3);

      // stop + clear + start together, then reset mid-run
      stop = 1'b1; clear = 1'b1; start = 1'b1; cyc(1);
      stop = 1'b0; clear = 1'b0; start = 1'b0;
      check("t6_idle", 32'(state), 32'd0);
      check("t6_cnt", cnt, 32'd0);
      pulse_start();
      cyc(5);
      rst = 1'b0; cyc(1); rst = 1'b1;
      check("t6_rst_state", 32'(state), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      cyc(2);

      // Random commands and config
      for (int r = 0; r < 3000; r++) begin
         start     = ($urandom_range(7) == 0);
         pause     = ($urandom_range(15) == 0);
         stop      = ($urandom_range(63) == 0);
         clear     = ($urandom_range(63) == 0);
         rst       = ($urandom_range(255) != 0);
         one_shot  = ($urandom_range(3) == 0);
         prescaler = $urandom_range(3);
         period    = $urandom_range(7);
         compare   = $urandom_range(9);
         cyc(1);
      end
      rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; clear = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
